// File: rtl/spi_lcd_rx_pkg.sv
// Shared LCD opcodes, register reset defaults and decoder helpers.
// The opcode constants are also used by the LCD init sequencer.
package spi_lcd_rx_pkg;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_MADCTL  = 8'h36;
  localparam logic [7:0] OP_PIXFMT  = 8'h3A;
  localparam logic [7:0] OP_PWCTR1  = 8'hC0;
  localparam logic [7:0] OP_PWCTR2  = 8'hC1;
  localparam logic [7:0] OP_VMCTR1  = 8'hC5;
  localparam logic [7:0] OP_VMCTR2  = 8'hC7;

  localparam logic [7:0]  MADCTL_DEF = 8'h00;
  localparam logic [7:0]  PIXFMT_DEF = 8'h66;
  localparam logic [7:0]  PWCTR1_DEF = 8'h21;
  localparam logic [7:0]  PWCTR2_DEF = 8'h10;
  localparam logic [15:0] VMCTR1_DEF = 16'h313C;
  localparam logic [7:0]  VMCTR2_DEF = 8'hC0;

  typedef enum logic {
    ST_NO_CMD = 1'b0,
    ST_IN_CMD = 1'b1
  } dec_state_t;

  function automatic logic [1:0] param_count(input logic [7:0] op);
    case (op)
      OP_MADCTL, OP_PIXFMT, OP_PWCTR1, OP_PWCTR2, OP_VMCTR2: param_count = 2'd1;
      OP_VMCTR1:                                             param_count = 2'd2;
      default:                                               param_count = 2'd0;
    endcase
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    case (op)
      OP_SWRESET, OP_SLPIN, OP_SLPOUT, OP_DISPOFF, OP_DISPON,
      OP_MADCTL, OP_PIXFMT, OP_PWCTR1, OP_PWCTR2, OP_VMCTR1, OP_VMCTR2: is_known = 1'b1;
      default:                                                         is_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_lcd_rx_byte_deser.sv
// SPI mode-0 byte deserializer oversampled by i_clk: input synchronizers,
// SCK rise detect, MSB-first shift, and abort on CS rising mid-byte.
module spi_byte_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sck,
  input  logic       i_mosi,
  input  logic       i_cs,
  input  logic       i_dc,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_is_data,
  output logic       rx_abort
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic                   sck_prev;
  logic [6:0]             shift_q;
  logic [2:0]             bit_cnt;

  logic sck_s, mosi_s, cs_s, dc_s, bit_strobe;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  assign bit_strobe = sck_s & ~sck_prev & ~cs_s;

  // The 8th bit is taken straight from the synchronizer so the top can
  // register the byte and its decode in the same cycle.
  assign rx_valid   = bit_strobe && (bit_cnt == 3'd7);
  assign rx_byte    = {shift_q, mosi_s};
  assign rx_is_data = dc_s;
  assign rx_abort   = cs_s && (bit_cnt != 3'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      sck_prev  <= 1'b0;
      shift_q   <= '0;
      bit_cnt   <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], i_dc};
      sck_prev  <= sck_s;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (bit_strobe) begin
        shift_q <= {shift_q[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/spi_lcd_rx.sv
// LCD command/parameter decoder and configuration register file fed by
// the SPI byte deserializer; models the receive side of an LCD panel.
//
// state     | meaning
// ST_NO_CMD | no command since reset/SWRESET; parameter bytes are errors
// ST_IN_CMD | o_cur_cmd holds the opcode, param_idx counts its parameters
module spi_lcd_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CMD_CNT_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sck,
  input  logic                 i_mosi,
  input  logic                 i_cs,
  input  logic                 i_dc,
  output logic [7:0]           o_byte,
  output logic                 o_byte_valid,
  output logic                 o_byte_is_data,
  output logic [7:0]           o_cur_cmd,
  output logic [7:0]           o_madctl,
  output logic [7:0]           o_pixfmt,
  output logic [7:0]           o_pwctr1,
  output logic [7:0]           o_pwctr2,
  output logic [15:0]          o_vmctr1,
  output logic [7:0]           o_vmctr2,
  output logic                 o_sleep_out,
  output logic                 o_disp_on,
  output logic [CMD_CNT_W-1:0] o_cmd_count,
  output logic                 o_err
);
  import spi_lcd_rx_pkg::*;

  localparam logic [CMD_CNT_W-1:0] CNT_ONE = {{(CMD_CNT_W-1){1'b0}}, 1'b1};

  logic [7:0] rx_byte;
  logic       rx_valid, rx_is_data, rx_abort;
  dec_state_t state;
  logic [1:0] param_idx;

  spi_byte_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sck      (i_sck),
    .i_mosi     (i_mosi),
    .i_cs       (i_cs),
    .i_dc       (i_dc),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_is_data (rx_is_data),
    .rx_abort   (rx_abort)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= ST_NO_CMD;
      param_idx      <= '0;
      o_byte         <= '0;
      o_byte_valid   <= 1'b0;
      o_byte_is_data <= 1'b0;
      o_cur_cmd      <= '0;
      o_madctl       <= MADCTL_DEF;
      o_pixfmt       <= PIXFMT_DEF;
      o_pwctr1       <= PWCTR1_DEF;
      o_pwctr2       <= PWCTR2_DEF;
      o_vmctr1       <= VMCTR1_DEF;
      o_vmctr2       <= VMCTR2_DEF;
      o_sleep_out    <= 1'b0;
      o_disp_on      <= 1'b0;
      o_cmd_count    <= '0;
      o_err          <= 1'b0;
    end else begin
      o_byte_valid <= rx_valid;
      o_err        <= rx_abort;
      if (rx_valid) begin
        o_byte         <= rx_byte;
        o_byte_is_data <= rx_is_data;
        if (!rx_is_data) begin
          // Command stays current across CS toggles until the next command.
          o_cur_cmd   <= rx_byte;
          o_cmd_count <= o_cmd_count + CNT_ONE;
          param_idx   <= '0;
          state       <= ST_IN_CMD;
          case (rx_byte)
            OP_SWRESET: begin
              o_madctl    <= MADCTL_DEF;
              o_pixfmt    <= PIXFMT_DEF;
              o_pwctr1    <= PWCTR1_DEF;
              o_pwctr2    <= PWCTR2_DEF;
              o_vmctr1    <= VMCTR1_DEF;
              o_vmctr2    <= VMCTR2_DEF;
              o_sleep_out <= 1'b0;
              o_disp_on   <= 1'b0;
              state       <= ST_NO_CMD;
            end
            OP_SLPOUT:  o_sleep_out <= 1'b1;
            OP_SLPIN:   o_sleep_out <= 1'b0;
            OP_DISPON:  o_disp_on   <= 1'b1;
            OP_DISPOFF: o_disp_on   <= 1'b0;
            default: ;
          endcase
        end else if (state == ST_NO_CMD) begin
          o_err <= 1'b1;
        end else if (param_idx < param_count(o_cur_cmd)) begin
          param_idx <= param_idx + 2'd1;
          case (o_cur_cmd)
            OP_MADCTL: o_madctl <= rx_byte;
            OP_PIXFMT: o_pixfmt <= rx_byte;
            OP_PWCTR1: o_pwctr1 <= rx_byte;
            OP_PWCTR2: o_pwctr2 <= rx_byte;
            OP_VMCTR2: o_vmctr2 <= rx_byte;
            OP_VMCTR1: begin
              if (param_idx == 2'd0) o_vmctr1[15:8] <= rx_byte;
              else                   o_vmctr1[7:0]  <= rx_byte;
            end
            default: ;
          endcase
        end else if (is_known(o_cur_cmd)) begin
          o_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Self-checking bench for spi_lcd_rx: directed LCD command sequences plus
// random command/parameter traffic compared against a behavioural model.
module tb_spi_lcd_rx;

  logic        i_clk = 1'b0;
  logic        i_rst, i_sck, i_mosi, i_cs, i_dc;
  logic [7:0]  o_byte, o_cur_cmd, o_madctl, o_pixfmt, o_pwctr1, o_pwctr2, o_vmctr2;
  logic [15:0] o_vmctr1;
  logic [7:0]  o_cmd_count;
  logic        o_byte_valid, o_byte_is_data, o_sleep_out, o_disp_on, o_err;

  spi_lcd_rx #(.SYNC_STAGES(2), .CMD_CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sck(i_sck), .i_mosi(i_mosi), .i_cs(i_cs), .i_dc(i_dc),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .o_byte_is_data(o_byte_is_data),
    .o_cur_cmd(o_cur_cmd), .o_madctl(o_madctl), .o_pixfmt(o_pixfmt), .o_pwctr1(o_pwctr1),
    .o_pwctr2(o_pwctr2), .o_vmctr1(o_vmctr1), .o_vmctr2(o_vmctr2), .o_sleep_out(o_sleep_out),
    .o_disp_on(o_disp_on), .o_cmd_count(o_cmd_count), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Pulse monitor, sampled 1 ns after each active edge.
  int         valid_seen = 0;
  int         err_seen   = 0;
  logic [7:0] snap_cmd, snap_cnt, snap_byte;
  always @(posedge i_clk) begin
    #1;
    if (o_byte_valid) begin
      valid_seen++;
      snap_cmd  = o_cur_cmd;
      snap_cnt  = o_cmd_count;
      snap_byte = o_byte;
    end
    if (o_err) err_seen++;
  end

  // Reference model: parameter bytes per opcode, plus flags and counters.
  logic [7:0] m_reg [0:255][0:1];
  logic       m_sleep, m_disp, m_have, exp_isd;
  logic [7:0] m_cmd, exp_byte;
  int         m_idx, exp_cmds, exp_valid, exp_err;

  function automatic int n_params(input logic [7:0] op);
    if (op inside {8'h36, 8'h3A, 8'hC0, 8'hC1, 8'hC7}) return 1;
    if (op == 8'hC5) return 2;
    return 0;
  endfunction

  function automatic bit known(input logic [7:0] op);
    return op inside {8'h01, 8'h10, 8'h11, 8'h28, 8'h29, 8'h36, 8'h3A, 8'hC0, 8'hC1, 8'hC5, 8'hC7};
  endfunction

  task automatic m_defaults();
    m_reg[8'h36][0] = 8'h00; m_reg[8'h3A][0] = 8'h66;
    m_reg[8'hC0][0] = 8'h21; m_reg[8'hC1][0] = 8'h10;
    m_reg[8'hC5][0] = 8'h31; m_reg[8'hC5][1] = 8'h3C;
    m_reg[8'hC7][0] = 8'hC0;
    m_sleep = 1'b0; m_disp = 1'b0; m_have = 1'b0;
  endtask

  task automatic m_reset();
    m_defaults();
    m_cmd = 8'h00; m_idx = 0; exp_cmds = 0; exp_byte = 8'h00; exp_isd = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b, input logic dc);
    exp_valid++; exp_byte = b; exp_isd = dc;
    if (!dc) begin
      exp_cmds++; m_cmd = b; m_idx = 0; m_have = 1'b1;
      case (b)
        8'h01: m_defaults();
        8'h11: m_sleep = 1'b1;
        8'h10: m_sleep = 1'b0;
        8'h29: m_disp = 1'b1;
        8'h28: m_disp = 1'b0;
        default: ;
      endcase
    end else if (!m_have) begin
      exp_err++;
    end else if (m_idx < n_params(m_cmd)) begin
      m_reg[m_cmd][m_idx] = b; m_idx++;
    end else if (known(m_cmd)) begin
      exp_err++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".byte"},    32'(o_byte), 32'(exp_byte));
    chk({tag, ".is_data"}, 32'(o_byte_is_data), 32'(exp_isd));
    chk({tag, ".cur_cmd"}, 32'(o_cur_cmd), 32'(m_cmd));
    chk({tag, ".madctl"},  32'(o_madctl), 32'(m_reg[8'h36][0]));
    chk({tag, ".pixfmt"},  32'(o_pixfmt), 32'(m_reg[8'h3A][0]));
    chk({tag, ".pwctr1"},  32'(o_pwctr1), 32'(m_reg[8'hC0][0]));
    chk({tag, ".pwctr2"},  32'(o_pwctr2), 32'(m_reg[8'hC1][0]));
    chk({tag, ".vmctr1"},  32'(o_vmctr1), 32'({m_reg[8'hC5][0], m_reg[8'hC5][1]}));
    chk({tag, ".vmctr2"},  32'(o_vmctr2), 32'(m_reg[8'hC7][0]));
    chk({tag, ".sleep"},   32'(o_sleep_out), 32'(m_sleep));
    chk({tag, ".disp"},    32'(o_disp_on), 32'(m_disp));
    chk({tag, ".cmd_cnt"}, 32'(o_cmd_count), exp_cmds & 255);
    chk({tag, ".n_valid"}, valid_seen, exp_valid);
    chk({tag, ".n_err"},   err_seen, exp_err);
  endtask

  // SCK = i_clk/8; every step starts on a falling i_clk edge.
  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      i_mosi = b[7-i];
      #40 i_sck = 1'b1;
      #40 i_sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] b, input logic dc, input string tag);
    i_dc = dc;
    spi_bits(b, 8);
    repeat (2) @(negedge i_clk);
    m_byte(b, dc);
    chk_all(tag);
    // Decode must already be visible in the cycle the valid pulse is seen.
    chk({tag, ".snap_byte"}, 32'(snap_byte), 32'(b));
    chk({tag, ".snap_cmd"},  32'(snap_cmd), 32'(m_cmd));
    chk({tag, ".snap_cnt"},  32'(snap_cnt), exp_cmds & 255);
  endtask

  task automatic cs_pulse();
    i_cs = 1'b1;
    repeat (6) @(negedge i_clk);
    i_cs = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_cs = 1'b1; i_sck = 1'b0;
    m_reset();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    i_cs = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  int e0, v0;
  logic [7:0] rop, rb;

  initial begin
    i_rst = 1'b1; i_sck = 1'b0; i_mosi = 1'b0; i_cs = 1'b1; i_dc = 1'b0;
    exp_valid = 0; exp_err = 0;
    m_reset();
    @(negedge i_clk);
    chk_all("reset");
    chk("reset.valid", 32'(o_byte_valid), 0);
    chk("reset.err", 32'(o_err), 0);
    do_reset();

    // 1: MADCTL write
    xfer(8'h36, 1'b0, "t1.cmd");
    xfer(8'h88, 1'b1, "t1.data");
    chk("t1.madctl", 32'(o_madctl), 32'h88);
    chk("t1.count", 32'(o_cmd_count), 1);
    chk("t1.err", err_seen, 0);

    // 2: VMCTR1 with CS toggle between phases, then one excess byte
    xfer(8'hC5, 1'b0, "t2.cmd");
    cs_pulse();
    xfer(8'h3E, 1'b1, "t2.p0");
    xfer(8'h28, 1'b1, "t2.p1");
    chk("t2.vmctr1", 32'(o_vmctr1), 32'h3E28);
    e0 = err_seen;
    xfer(8'h11, 1'b1, "t2.excess");
    chk("t2.err_pulse", err_seen - e0, 1);
    chk("t2.vmctr1_hold", 32'(o_vmctr1), 32'h3E28);

    // 3: full init stream
    do_reset();
    xfer(8'h01, 1'b0, "t3.swreset");
    xfer(8'hC0, 1'b0, "t3.c0"); xfer(8'h23, 1'b1, "t3.c0p");
    xfer(8'hC1, 1'b0, "t3.c1"); xfer(8'h10, 1'b1, "t3.c1p");
    xfer(8'hC5, 1'b0, "t3.c5"); xfer(8'h3E, 1'b1, "t3.c5p0"); xfer(8'h28, 1'b1, "t3.c5p1");
    xfer(8'hC7, 1'b0, "t3.c7"); xfer(8'h86, 1'b1, "t3.c7p");
    xfer(8'h36, 1'b0, "t3.36"); xfer(8'h88, 1'b1, "t3.36p");
    xfer(8'h3A, 1'b0, "t3.3a"); xfer(8'h55, 1'b1, "t3.3ap");
    xfer(8'h11, 1'b0, "t3.slpout");
    xfer(8'h29, 1'b0, "t3.dispon");
    chk("t3.pwctr1", 32'(o_pwctr1), 32'h23);
    chk("t3.pwctr2", 32'(o_pwctr2), 32'h10);
    chk("t3.vmctr1", 32'(o_vmctr1), 32'h3E28);
    chk("t3.vmctr2", 32'(o_vmctr2), 32'h86);
    chk("t3.madctl", 32'(o_madctl), 32'h88);
    chk("t3.pixfmt", 32'(o_pixfmt), 32'h55);
    chk("t3.sleep", 32'(o_sleep_out), 1);
    chk("t3.disp", 32'(o_disp_on), 1);
    chk("t3.count", 32'(o_cmd_count), 9);

    // SCK activity with CS high must be ignored
    i_cs = 1'b1;
    repeat (4) @(negedge i_clk);
    i_dc = 1'b0;
    spi_bits(8'h28, 8);
    repeat (4) @(negedge i_clk);
    i_cs = 1'b0;
    repeat (2) @(negedge i_clk);
    chk_all("cs_high_ignored");

    // 4: CS abort after 5 bits, then a clean byte
    e0 = err_seen; v0 = valid_seen;
    i_dc = 1'b0;
    spi_bits(8'hC0, 5);
    cs_pulse();
    exp_err++;
    chk("t4.err_pulse", err_seen - e0, 1);
    chk("t4.no_valid", valid_seen - v0, 0);
    xfer(8'h3A, 1'b0, "t4.next");
    chk("t4.cur_cmd", 32'(o_cur_cmd), 32'h3A);

    // 5: SWRESET restores defaults, following parameter is an error
    xfer(8'h29, 1'b0, "t5.dispon");
    xfer(8'h01, 1'b0, "t5.swreset");
    chk("t5.pixfmt", 32'(o_pixfmt), 32'h66);
    chk("t5.disp", 32'(o_disp_on), 0);
    e0 = err_seen;
    xfer(8'h12, 1'b1, "t5.orphan");
    chk("t5.err_pulse", err_seen - e0, 1);

    // 6: async reset during bit 4 of a byte
    i_dc = 1'b1;
    spi_bits(8'hA5, 4);
    #3;
    i_rst = 1'b1; i_cs = 1'b1;
    m_reset();
    #1;
    chk_all("t6.in_reset");
    chk("t6.valid", 32'(o_byte_valid), 0);
    chk("t6.err", 32'(o_err), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    i_cs = 1'b0;
    repeat (2) @(negedge i_clk);
    xfer(8'h29, 1'b0, "t6.dispon");
    chk("t6.disp", 32'(o_disp_on), 1);
    chk("t6.count", 32'(o_cmd_count), 1);

    // Random command/parameter traffic against the model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 11))
        0: rop = 8'h01;  1: rop = 8'h10;  2: rop = 8'h11;  3: rop = 8'h28;
        4: rop = 8'h29;  5: rop = 8'h36;  6: rop = 8'h3A;  7: rop = 8'hC0;
        8: rop = 8'hC1;  9: rop = 8'hC5;  10: rop = 8'hC7;
        default: rop = 8'($urandom_range(0, 255));
      endcase
      xfer(rop, 1'b0, "rnd.cmd");
      for (int p = 0, np = $urandom_range(0, 3); p < np; p++) begin
        if ($urandom_range(0, 3) == 0) cs_pulse();
        rb = 8'($urandom_range(0, 255));
        xfer(rb, 1'b1, "rnd.param");
      end
      if ($urandom_range(0, 7) == 0) begin
        i_dc = 1'($urandom_range(0, 1));
        spi_bits(8'($urandom_range(0, 255)), $urandom_range(1, 7));
        cs_pulse();
        exp_err++;
        chk_all("rnd.abort");
      end
    end

    // Command counter wraps after 256 commands
    v0 = exp_cmds & 255;
    for (int k = 0; k < 256; k++) xfer(8'h00, 1'b0, "wrap.cmd");
    chk("wrap.count", 32'(o_cmd_count), 32'(v0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
